pll_reconfig_ctrl: RTL
======================

PLL_RECONFIG_CTRL -- requirements
Module: pll_reconfig_ctrl

Interface
REQ-001 Parameter PROF_N, default 128'h0, holds four 32-bit N-counter words; profile k occupies bits [32k+31:32k].
REQ-002 Parameter PROF_M, default 128'h0, holds four 32-bit M-counter words; same packing as PROF_N.
REQ-003 Parameter PROF_C0, default 128'h0, holds four 32-bit C-counter words for output 0, with the counter-select field pre-encoded; same packing.
REQ-004 Parameter PROF_C1, default 128'h0, holds four 32-bit C-counter words for output 1; same packing.
REQ-005 Parameter LOCK_HOLD, default 16, is the number of consecutive cycles pll_locked must be high before the run counts as complete.
REQ-006 Parameter TIMEOUT, default 1000000, is the maximum number of cycles allowed from entering POLL to completion.
REQ-007 Port refclk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-008 Port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-009 Port cfg_req, input, 1 bit: request to reconfigure the PLL.
REQ-010 Port cfg_mode, input, 2 bits: profile index 0-3.
REQ-011 Port pll_locked, input, 1 bit: PLL lock indicator, already synchronous to refclk.
REQ-012 Port mgmt_waitrequest, input, 1 bit: stall from the reconfig slave.
REQ-013 Port mgmt_readdata, input, 32 bits: read data from the reconfig slave.
REQ-014 Port mgmt_address, output, 6 bits: reconfig register address.
REQ-015 Port mgmt_read, output, 1 bit: read strobe.
REQ-016 Port mgmt_write, output, 1 bit: write strobe.
REQ-017 Port mgmt_writedata, output, 32 bits: write data.
REQ-018 Port busy, output, 1 bit: high while a sequence is in progress.
REQ-019 Port done, output, 1 bit: one-cycle pulse on successful completion.
REQ-020 Port err, output, 1 bit: sticky timeout flag.
REQ-021 Port cur_mode, output, 2 bits: last successfully applied profile.

Function
REQ-022 FSM states: IDLE, WR_MODE, WR_N, WR_M, WR_C0, WR_C1, WR_START, POLL, WAIT_LOCK, FIN.
REQ-023 In IDLE, cfg_req=1 latches cfg_mode into an internal profile register, sets busy=1, clears err, and moves to WR_MODE on the next cycle.
REQ-024 Write state address and data:
- WR_MODE: address 0, data 32'h1 (polling mode).
- WR_N: address 3, data PROF_N[profile].
- WR_M: address 4, data PROF_M[profile].
- WR_C0: address 5, data PROF_C0[profile].
- WR_C1: address 5, data PROF_C1[profile].
- WR_START: address 2, data 32'h0.
REQ-025 Avalon-MM write handshake: in each write state, mgmt_write=1 and address/data are held stable; the transfer completes on the cycle where mgmt_write=1 and mgmt_waitrequest=0, and the FSM advances on the following edge.
REQ-026 mgmt_read and mgmt_write are never high in the same cycle.
REQ-027 mgmt_read is high only in POLL, and mgmt_write only in the write states.
REQ-028 Outside its owning state, each strobe is low.
REQ-029 POLL behaviour:
- Drive mgmt_read=1 with address 1.
- A read completes when mgmt_waitrequest=0; mgmt_readdata is sampled in that same cycle.
- Sampled bit0=1 -> go to WAIT_LOCK.
- Sampled bit0=0 -> drop mgmt_read for one cycle, then reissue the read.
REQ-030 WAIT_LOCK: a hold counter increments each cycle pll_locked=1 and clears to 0 whenever pll_locked=0; reaching LOCK_HOLD moves to FIN.
REQ-031 A 20-bit timeout counter clears on entering POLL and increments each cycle in POLL or WAIT_LOCK; on reaching TIMEOUT, set err=1, deassert the strobes, and return to IDLE with busy=0, without pulsing done and without updating cur_mode.
REQ-032 FIN, for one cycle: done=1, cur_mode takes the latched profile, and the next state is IDLE with busy=0.
REQ-033 cfg_req is ignored while busy=1; cfg_mode changes after acceptance have no effect on the running sequence.
REQ-034 cfg_req held high in IDLE starts a new sequence on the first IDLE cycle after FIN or timeout.
REQ-035 Write-state waitrequest has no timeout; the slave is required to eventually accept writes.

Reset
REQ-036 When rst_n=0 on a clock edge, the state becomes IDLE and all outputs go low or zero (busy, done, err, strobes, address, writedata, cur_mode=0) on that edge, including mid-transfer with waitrequest high.
REQ-037 Hold and timeout counters clear on reset; the first accepted cfg_req after reset release starts at WR_MODE.

Verification
REQ-038 Profile 2, slave waitrequest=0 always, status bit0=1 on first read, pll_locked=1, LOCK_HOLD=4 -> six writes in the order 0,3,4,5,5,2 on consecutive accepted cycles with PROF words [95:64], one read, done pulses once, cur_mode=2.
REQ-039 Waitrequest high for 3 cycles on the WR_M write -> address 4 and its data held stable for 4 cycles, and exactly one write accepted.
REQ-040 Status reads return 0, 0, then 1 -> three read transfers with a one-cycle gap between each, then WAIT_LOCK.
REQ-041 pll_locked pattern 1,1,0,1,1,1,1 with LOCK_HOLD=4 -> done asserts only after the final four consecutive highs.
REQ-042 TIMEOUT=100, pll_locked stuck low -> err=1 and busy=0 100 cycles after POLL entry, no done, cur_mode unchanged.
REQ-043 rst_n=0 while mgmt_write=1 and waitrequest=1 -> strobes low on the same edge; after release, cfg_req=1 restarts at WR_MODE.

Source files
------------

// File: rtl/pll_reconfig_ctrl.sv
// Writes one of four stored PLL profiles to the reconfig slave, then polls its status and waits for a stable lock.
// Outputs are registered; a held strobe keeps its address and data stable until mgmt_waitrequest drops.
module pll_reconfig_ctrl #(
  parameter logic [127:0] PROF_N    = 128'h0,
  parameter logic [127:0] PROF_M    = 128'h0,
  parameter logic [127:0] PROF_C0   = 128'h0,
  parameter logic [127:0] PROF_C1   = 128'h0,
  parameter int           LOCK_HOLD = 16,
  parameter int           TIMEOUT   = 1000000
) (
  input  logic        refclk,
  input  logic        rst_n,
  input  logic        cfg_req,
  input  logic [1:0]  cfg_mode,
  input  logic        pll_locked,
  input  logic        mgmt_waitrequest,
  input  logic [31:0] mgmt_readdata,
  output logic [5:0]  mgmt_address,
  output logic        mgmt_read,
  output logic        mgmt_write,
  output logic [31:0] mgmt_writedata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [1:0]  cur_mode
);

  typedef enum logic [3:0] {
    IDLE, WR_MODE, WR_N, WR_M, WR_C0, WR_C1, WR_START, POLL, WAIT_LOCK, FIN
  } state_t;

  localparam int              HW        = (LOCK_HOLD > 1) ? $clog2(LOCK_HOLD + 1) : 1;
  localparam logic [HW-1:0]   HOLD_LAST = HW'(LOCK_HOLD - 1);
  localparam logic [19:0]     TMO_LAST  = 20'(TIMEOUT - 1);

  state_t        state_q, state_d;
  logic [1:0]    prof_q, prof_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [19:0]   tmo_q, tmo_d;
  logic [5:0]    addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          wr_q, wr_d;
  logic          rd_q, rd_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [1:0]    cur_mode_q, cur_mode_d;
  logic [6:0]    sel;
  logic          wr_ack, rd_ack;
  logic          unused_rdata;

  assign wr_ack       = wr_q & ~mgmt_waitrequest;
  assign rd_ack       = rd_q & ~mgmt_waitrequest;
  assign unused_rdata = ^mgmt_readdata[31:1];

  always_comb begin
    state_d    = state_q;
    prof_d     = prof_q;
    hold_d     = hold_q;
    tmo_d      = tmo_q;
    err_d      = err_q;
    cur_mode_d = cur_mode_q;
    rd_d       = 1'b0;
    case (state_q)
      IDLE: if (cfg_req) begin
        state_d = WR_MODE;
        prof_d  = cfg_mode;
        err_d   = 1'b0;
      end
      WR_MODE:  if (wr_ack) state_d = WR_N;
      WR_N:     if (wr_ack) state_d = WR_M;
      WR_M:     if (wr_ack) state_d = WR_C0;
      WR_C0:    if (wr_ack) state_d = WR_C1;
      WR_C1:    if (wr_ack) state_d = WR_START;
      WR_START: if (wr_ack) begin
        state_d = POLL;
        tmo_d   = '0;
        rd_d    = 1'b1;
      end
      POLL: begin
        tmo_d = tmo_q + 20'd1;
        if (rd_ack && mgmt_readdata[0]) begin
          state_d = WAIT_LOCK;
          hold_d  = '0;
        end else begin
          // a not-ready status read leaves the strobe low for one cycle before retrying
          rd_d = ~rd_ack;
        end
      end
      WAIT_LOCK: begin
        tmo_d = tmo_q + 20'd1;
        if (!pll_locked) begin
          hold_d = '0;
        end else if (hold_q == HOLD_LAST) begin
          state_d    = FIN;
          cur_mode_d = prof_q;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if ((state_q == POLL || state_q == WAIT_LOCK) && tmo_q == TMO_LAST) begin
      state_d    = IDLE;
      err_d      = 1'b1;
      rd_d       = 1'b0;
      cur_mode_d = cur_mode_q;
    end

    // strobe, address and data follow the state being entered so they line up with it
    sel     = {prof_d, 5'd0};
    wr_d    = 1'b0;
    addr_d  = '0;
    wdata_d = '0;
    case (state_d)
      WR_MODE:  begin wr_d = 1'b1; addr_d = 6'd0; wdata_d = 32'h1; end
      WR_N:     begin wr_d = 1'b1; addr_d = 6'd3; wdata_d = PROF_N[sel +: 32]; end
      WR_M:     begin wr_d = 1'b1; addr_d = 6'd4; wdata_d = PROF_M[sel +: 32]; end
      WR_C0:    begin wr_d = 1'b1; addr_d = 6'd5; wdata_d = PROF_C0[sel +: 32]; end
      WR_C1:    begin wr_d = 1'b1; addr_d = 6'd5; wdata_d = PROF_C1[sel +: 32]; end
      WR_START: begin wr_d = 1'b1; addr_d = 6'd2; end
      POLL:     addr_d = 6'd1;
      default:  ;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == FIN);
  end

  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      prof_q     <= '0;
      hold_q     <= '0;
      tmo_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wr_q       <= 1'b0;
      rd_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      cur_mode_q <= '0;
    end else begin
      state_q    <= state_d;
      prof_q     <= prof_d;
      hold_q     <= hold_d;
      tmo_q      <= tmo_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      cur_mode_q <= cur_mode_d;
    end
  end

  assign mgmt_address   = addr_q;
  assign mgmt_writedata = wdata_q;
  assign mgmt_write     = wr_q;
  assign mgmt_read      = rd_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign err            = err_q;
  assign cur_mode       = cur_mode_q;

endmodule
